ccip_avmm_mmio_master: RTL



---
 rtl/ccip_avmm_mmio_master.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ccip_avmm_mmio_master.sv
// CCI-P MMIO to Avalon-MM master bridge: formats decoded MMIO packets, queues them,
// issues them in order on Avalon-MM and returns read data tagged with the MMIO TID.
package ccip_avmm_pkg;
    typedef struct packed {
        logic        is_read;
        logic        is_32bit;
        logic [17:0] addr;
        logic [63:0] write_data;
    } t_ccip_avmm_mmio_cmd;

    typedef struct packed {
        logic [17:0] address;
        logic [7:0]  byteenable;
        logic [63:0] writedata;
        logic        read;
        logic        write;
        logic [8:0]  tid;
        logic        is_32bit;
        logic        addr2;
    } t_master_cmd_queue;

    typedef struct packed {
        logic [8:0] tid;
        logic       is_32bit;
        logic       addr2;
    } t_rd_track;
endpackage

module ccip_avmm_mmio_master
    import ccip_avmm_pkg::*;
#(
    parameter int CMD_DEPTH = 16,
    parameter int MAX_RD    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                mmio_cmd_valid,
    input  t_ccip_avmm_mmio_cmd mmio_cmd,
    input  logic [8:0]          mmio_tid,
    output logic [17:0]         avm_address,
    output logic [7:0]          avm_byteenable,
    output logic [63:0]         avm_writedata,
    output logic                avm_read,
    output logic                avm_write,
    input  logic                avm_waitrequest,
    input  logic [63:0]         avm_readdata,
    input  logic                avm_readdatavalid,
    output logic                rd_rsp_valid,
    output logic [8:0]          rd_rsp_tid,
    output logic [63:0]         rd_rsp_data,
    output logic                err_overflow,
    output logic                err_unexp_rsp
);
    localparam int QPW = $clog2(CMD_DEPTH);
    localparam int QCW = QPW + 1;
    localparam int TPW = (MAX_RD > 1) ? $clog2(MAX_RD) : 1;
    localparam int TCW = $clog2(MAX_RD) + 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    t_master_cmd_queue avm_q, avm_d;
    t_master_cmd_queue fmt, head;
    t_master_cmd_queue q_mem [CMD_DEPTH];
    t_rd_track         trk_mem [MAX_RD];
    t_rd_track         trk_head;

    logic [QPW-1:0] q_wr_ptr_q, q_wr_ptr_d, q_rd_ptr_q, q_rd_ptr_d;
    logic [QCW-1:0] q_cnt_q, q_cnt_d;
    logic [TPW-1:0] trk_wr_ptr_q, trk_wr_ptr_d, trk_rd_ptr_q, trk_rd_ptr_d;
    logic [TCW-1:0] trk_cnt_q, trk_cnt_d;
    logic           q_push, q_pop, trk_push, trk_pop, head_ok;
    logic           rsp_valid_q, rsp_valid_d;
    logic [8:0]     rsp_tid_q, rsp_tid_d;
    logic [63:0]    rsp_data_q, rsp_data_d;
    logic [31:0]    rsp_half;
    logic           err_ovf_q, err_ovf_d, err_unexp_q, err_unexp_d;

    always_comb begin
        fmt            = '0;
        fmt.address    = {mmio_cmd.addr[17:3], 3'b000};
        fmt.byteenable = 8'hFF;
        fmt.writedata  = mmio_cmd.write_data;
        if (mmio_cmd.is_32bit) begin
            fmt.byteenable = mmio_cmd.addr[2] ? 8'hF0 : 8'h0F;
            fmt.writedata  = {mmio_cmd.write_data[31:0], mmio_cmd.write_data[31:0]};
        end
        fmt.read     = mmio_cmd.is_read;
        fmt.write    = !mmio_cmd.is_read;
        fmt.tid      = mmio_tid;
        fmt.is_32bit = mmio_cmd.is_32bit;
        fmt.addr2    = mmio_cmd.addr[2];
    end

    // Read eligibility looks at the tracker occupancy after this edge, so a
    // returning response frees a slot for a read loaded on the same edge.
    always_comb begin
        head      = q_mem[q_rd_ptr_q];
        trk_head  = trk_mem[trk_rd_ptr_q];
        trk_pop   = avm_readdatavalid && (trk_cnt_q != '0);
        trk_push  = (state_q == BUSY) && !avm_waitrequest && avm_q.read;
        trk_cnt_d = trk_cnt_q + TCW'(trk_push) - TCW'(trk_pop);
        head_ok   = (q_cnt_q != '0) && (!head.read || (trk_cnt_d < TCW'(MAX_RD)));

        state_d = state_q;
        avm_d   = avm_q;
        q_pop   = 1'b0;
        case (state_q)
            IDLE: begin
                if (head_ok) begin
                    avm_d   = head;
                    q_pop   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!avm_waitrequest) begin
                    if (head_ok) begin
                        avm_d = head;
                        q_pop = 1'b1;
                    end else begin
                        avm_d.read  = 1'b0;
                        avm_d.write = 1'b0;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        q_push     = mmio_cmd_valid && ((q_cnt_q != QCW'(CMD_DEPTH)) || q_pop);
        q_cnt_d    = q_cnt_q + QCW'(q_push) - QCW'(q_pop);
        q_wr_ptr_d = q_push ? q_wr_ptr_q + QPW'(1) : q_wr_ptr_q;
        q_rd_ptr_d = q_pop  ? q_rd_ptr_q + QPW'(1) : q_rd_ptr_q;

        trk_wr_ptr_d = trk_wr_ptr_q;
        trk_rd_ptr_d = trk_rd_ptr_q;
        if (trk_push)
            trk_wr_ptr_d = (trk_wr_ptr_q == TPW'(MAX_RD - 1)) ? '0 : trk_wr_ptr_q + TPW'(1);
        if (trk_pop)
            trk_rd_ptr_d = (trk_rd_ptr_q == TPW'(MAX_RD - 1)) ? '0 : trk_rd_ptr_q + TPW'(1);

        rsp_half    = trk_head.addr2 ? avm_readdata[63:32] : avm_readdata[31:0];
        rsp_valid_d = trk_pop;
        rsp_tid_d   = trk_pop ? trk_head.tid : rsp_tid_q;
        rsp_data_d  = rsp_data_q;
        if (trk_pop)
            rsp_data_d = trk_head.is_32bit ? {rsp_half, rsp_half} : avm_readdata;

        err_ovf_d   = err_ovf_q || (mmio_cmd_valid && !q_push);
        err_unexp_d = err_unexp_q || (avm_readdatavalid && (trk_cnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (q_push)
            q_mem[q_wr_ptr_q] <= fmt;
        if (trk_push)
            trk_mem[trk_wr_ptr_q] <= '{tid: avm_q.tid, is_32bit: avm_q.is_32bit, addr2: avm_q.addr2};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            avm_q        <= '0;
            q_wr_ptr_q   <= '0;
            q_rd_ptr_q   <= '0;
            q_cnt_q      <= '0;
            trk_wr_ptr_q <= '0;
            trk_rd_ptr_q <= '0;
            trk_cnt_q    <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_tid_q    <= '0;
            rsp_data_q   <= '0;
            err_ovf_q    <= 1'b0;
            err_unexp_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            avm_q        <= avm_d;
            q_wr_ptr_q   <= q_wr_ptr_d;
            q_rd_ptr_q   <= q_rd_ptr_d;
            q_cnt_q      <= q_cnt_d;
            trk_wr_ptr_q <= trk_wr_ptr_d;
            trk_rd_ptr_q <= trk_rd_ptr_d;
            trk_cnt_q    <= trk_cnt_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_tid_q    <= rsp_tid_d;
            rsp_data_q   <= rsp_data_d;
            err_ovf_q    <= err_ovf_d;
            err_unexp_q  <= err_unexp_d;
        end
    end

    assign avm_address    = avm_q.address;
    assign avm_byteenable = avm_q.byteenable;
    assign avm_writedata  = avm_q.writedata;
    assign avm_read       = avm_q.read;
    assign avm_write      = avm_q.write;
    assign rd_rsp_valid   = rsp_valid_q;
    assign rd_rsp_tid     = rsp_tid_q;
    assign rd_rsp_data    = rsp_data_q;
    assign err_overflow   = err_ovf_q;
    assign err_unexp_rsp  = err_unexp_q;
endmodule
